// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write arbiter.
//   arb_state_e : arbiter FSM states (idle / grant held by one owner)
//   id_width()  : width of an index into n items, never less than one bit
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StGrant = 1'b1
    } arb_state_e;

    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker.
// Scans req_i starting at index start_i, wrapping modulo N, and reports the first set bit.
//   req_i   : request vector
//   start_i : index given highest priority (must be < N)
//   gnt_o   : one-hot of the chosen request, zero when none
//   idx_o   : index of the chosen request
//   valid_o : at least one request was set
module rr_priority_pick
    import fifo_arb_pkg::*;
#(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = id_width(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] start_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    int unsigned   pos;
    logic [IW-1:0] pos_idx;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        pos     = 0;
        pos_idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            pos = 32'(start_i) + i;
            if (pos >= N) begin
                pos = pos - N;
            end
            pos_idx = IW'(pos);
            if (!valid_o && req_i[pos_idx]) begin
                valid_o        = 1'b1;
                gnt_o[pos_idx] = 1'b1;
                idx_o          = pos_idx;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter granting NREQ write requesters bursts of up to BURST words into one FIFO.
//   clk, rst_n      : clock, asynchronous active-low reset
//   req_i / data_i  : per-requester request and data (requester k at data_i[k*DW +: DW])
//   ack_o           : word from requester k accepted this cycle
//   grant_o         : registered one-hot owner, zero when idle
//   fifo_full_i     : downstream FIFO full, stalls the current owner
//   fifo_wr_en_o    : FIFO write strobe
//   fifo_wr_data_o  : {owner id, owner data} while granted, zero when idle
//   busy_o          : a grant is held
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int unsigned NREQ  = 4,
    parameter  int unsigned DW    = 8,
    parameter  int unsigned BURST = 4,
    localparam int unsigned IDW   = id_width(NREQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_i,
    input  logic [NREQ*DW-1:0] data_i,
    output logic [NREQ-1:0]    ack_o,
    output logic [NREQ-1:0]    grant_o,
    input  logic               fifo_full_i,
    output logic               fifo_wr_en_o,
    output logic [IDW+DW-1:0]  fifo_wr_data_o,
    output logic               busy_o
);

    localparam int unsigned    CW       = id_width(BURST);
    localparam logic [CW-1:0]  CntMax   = CW'(BURST - 1);
    localparam logic [IDW-1:0] LastInit = IDW'(NREQ - 1);

    arb_state_e     state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [IDW-1:0] owner_q, owner_d;
    logic [IDW-1:0] last_q,  last_d;
    logic [CW-1:0]  cnt_q,   cnt_d;

    logic [DW-1:0]   data_arr [NREQ];
    logic [IDW-1:0]  pick_start;
    logic [NREQ-1:0] pick_gnt;
    logic [IDW-1:0]  pick_idx;
    logic            pick_valid;
    logic            ack_any;
    logic            release_w;

    always_comb begin
        for (int unsigned k = 0; k < NREQ; k++) begin
            data_arr[k] = data_i[k*DW +: DW];
        end
    end

    // last_q tracks the owner of every new grant, so in GRANT it equals the current owner and
    // starting at last_q+1 leaves the current owner eligible last.
    assign pick_start = (last_q == LastInit) ? '0 : last_q + IDW'(1);

    rr_priority_pick #(
        .N (NREQ)
    ) u_pick (
        .req_i   (req_i),
        .start_i (pick_start),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    // grant_q is cleared asynchronously by reset, which also forces ack low during reset.
    assign ack_o        = grant_q & req_i & {NREQ{~fifo_full_i}};
    assign ack_any      = |ack_o;
    assign fifo_wr_en_o = ack_any;
    assign grant_o      = grant_q;
    assign busy_o       = (state_q == StGrant);

    assign fifo_wr_data_o = busy_o ? {owner_q, data_arr[owner_q]} : '0;

    assign release_w = (state_q == StGrant) &&
                       ((ack_any && (cnt_q == CntMax)) || !req_i[owner_q]);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    state_d = StGrant;
                    grant_d = pick_gnt;
                    owner_d = pick_idx;
                    last_d  = pick_idx;
                    cnt_d   = '0;
                end
            end
            StGrant: begin
                if (release_w) begin
                    if (pick_valid) begin
                        // Direct hand-over, no idle bubble.
                        grant_d = pick_gnt;
                        owner_d = pick_idx;
                        last_d  = pick_idx;
                        cnt_d   = '0;
                    end else begin
                        state_d = StIdle;
                        grant_d = '0;
                        cnt_d   = '0;
                    end
                end else if (ack_any) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            grant_q <= '0;
            owner_q <= '0;
            last_q  <= LastInit;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (NREQ=4, DW=8, BURST=4).
module tb_fifo_wr_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_i;
    logic [31:0] data_i;
    logic [3:0]  ack_o;
    logic [3:0]  grant_o;
    logic        fifo_full_i;
    logic        fifo_wr_en_o;
    logic [9:0]  fifo_wr_data_o;
    logic        busy_o;

    int n_cmp;
    int n_bad;

    fifo_wr_arbiter #(
        .NREQ  (4),
        .DW    (8),
        .BURST (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_i          (req_i),
        .data_i         (data_i),
        .ack_o          (ack_o),
        .grant_o        (grant_o),
        .fifo_full_i    (fifo_full_i),
        .fifo_wr_en_o   (fifo_wr_en_o),
        .fifo_wr_data_o (fifo_wr_data_o),
        .busy_o         (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        req_i       = 4'b0000;
        fifo_full_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        req_i       = 4'b1111;
        fifo_full_i = 1'b0;
        tick();
        n_cmp++;
        if (grant_o !== 4'b0000) begin
            n_bad++; $display("FAIL reset_grant: got %b want 0000", grant_o);
        end
        n_cmp++;
        if (ack_o !== 4'b0000 || fifo_wr_en_o !== 1'b0) begin
            n_bad++; $display("FAIL reset_ack: got ack %b wr_en %b want 0000/0", ack_o, fifo_wr_en_o);
        end
        n_cmp++;
        if (busy_o !== 1'b0 || fifo_wr_data_o !== 10'h000) begin
            n_bad++; $display("FAIL reset_busy_data: got busy %b data %h want 0/000", busy_o, fifo_wr_data_o);
        end
        tick();
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (grant_o !== 4'b0000) begin
            n_bad++; $display("FAIL reset_release_no_grant: got %b want 0000", grant_o);
        end
        tick();
        n_cmp++;
        if (grant_o !== 4'b0001 || busy_o !== 1'b1 || ack_o !== 4'b0001) begin
            n_bad++; $display("FAIL reset_first_grant: got grant %b busy %b ack %b want 0001/1/0001", grant_o, busy_o, ack_o);
        end
    endtask

    task automatic test_single();
        do_reset();
        req_i = 4'b0001;
        #1;
        n_cmp++;
        if (grant_o !== 4'b0000 || ack_o !== 4'b0000) begin
            n_bad++; $display("FAIL single_latency: got grant %b ack %b want 0000/0000", grant_o, ack_o);
        end
        tick();
        for (int i = 0; i < 12; i++) begin
            #1;
            n_cmp++;
            if (grant_o !== 4'b0001 || ack_o !== 4'b0001 || fifo_wr_en_o !== 1'b1 ||
                fifo_wr_data_o !== 10'h0A0) begin
                n_bad++;
                $display("FAIL single_cycle%0d: got grant %b ack %b wr_en %b data %h want 0001/0001/1/0a0", i, grant_o, ack_o, fifo_wr_en_o, fifo_wr_data_o);
            end
            tick();
        end
        req_i = 4'b0000;
        #1;
        n_cmp++;
        if (ack_o !== 4'b0000) begin
            n_bad++; $display("FAIL single_drop_ack: got %b want 0000", ack_o);
        end
        tick();
        #1;
        n_cmp++;
        if (grant_o !== 4'b0000 || busy_o !== 1'b0 || fifo_wr_data_o !== 10'h000) begin
            n_bad++; $display("FAIL single_idle: got grant %b busy %b data %h want 0000/0/000", grant_o, busy_o, fifo_wr_data_o);
        end
    endtask

    task automatic test_all_req();
        int        owners [5];
        logic [3:0] exp_g;
        logic [9:0] exp_d;
        logic [1:0] id;
        owners = '{0, 1, 2, 3, 0};
        do_reset();
        req_i = 4'b1111;
        #1;
        n_cmp++;
        if (grant_o !== 4'b0000) begin
            n_bad++; $display("FAIL all_latency: got %b want 0000", grant_o);
        end
        tick();
        for (int b = 0; b < 5; b++) begin
            id    = 2'(owners[b]);
            exp_g = 4'b0001 << owners[b];
            exp_d = {id, 8'hA0 + 8'(owners[b])};
            for (int w = 0; w < 4; w++) begin
                #1;
                n_cmp++;
                if (grant_o !== exp_g || ack_o !== exp_g || fifo_wr_data_o !== exp_d) begin
                    n_bad++;
                    $display("FAIL all_burst%0d_word%0d: got grant %b ack %b data %h want %b/%b/%h", b, w, grant_o, ack_o, fifo_wr_data_o, exp_g, exp_g, exp_d);
                end
                tick();
            end
        end
    endtask

    task automatic test_full_stall();
        do_reset();
        req_i = 4'b0010;
        #1;
        tick();
        for (int w = 0; w < 2; w++) begin
            #1;
            n_cmp++;
            if (grant_o !== 4'b0010 || ack_o !== 4'b0010) begin
                n_bad++; $display("FAIL full_pre%0d: got grant %b ack %b want 0010/0010", w, grant_o, ack_o);
            end
            tick();
        end
        fifo_full_i = 1'b1;
        req_i       = 4'b0011;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_cmp++;
            if (grant_o !== 4'b0010 || ack_o !== 4'b0000 || fifo_wr_en_o !== 1'b0) begin
                n_bad++; $display("FAIL full_stall%0d: got grant %b ack %b wr_en %b want 0010/0000/0", c, grant_o, ack_o, fifo_wr_en_o);
            end
            tick();
        end
        fifo_full_i = 1'b0;
        for (int w = 0; w < 2; w++) begin
            #1;
            n_cmp++;
            if (grant_o !== 4'b0010 || ack_o !== 4'b0010 || fifo_wr_data_o !== 10'h1A1) begin
                n_bad++; $display("FAIL full_post%0d: got grant %b ack %b data %h want 0010/0010/1a1", w, grant_o, ack_o, fifo_wr_data_o);
            end
            tick();
        end
        #1;
        n_cmp++;
        if (grant_o !== 4'b0001 || ack_o !== 4'b0001) begin
            n_bad++; $display("FAIL full_release: got grant %b ack %b want 0001/0001", grant_o, ack_o);
        end
    endtask

    task automatic test_drop();
        do_reset();
        req_i = 4'b0100;
        #1;
        tick();
        req_i = 4'b1101;
        #1;
        n_cmp++;
        if (grant_o !== 4'b0100 || ack_o !== 4'b0100) begin
            n_bad++; $display("FAIL drop_first: got grant %b ack %b want 0100/0100", grant_o, ack_o);
        end
        tick();
        req_i = 4'b1001;
        #1;
        n_cmp++;
        if (ack_o !== 4'b0000 || fifo_wr_en_o !== 1'b0 || busy_o !== 1'b1) begin
            n_bad++; $display("FAIL drop_cycle: got ack %b wr_en %b busy %b want 0000/0/1", ack_o, fifo_wr_en_o, busy_o);
        end
        tick();
        for (int w = 0; w < 4; w++) begin
            #1;
            n_cmp++;
            if (grant_o !== 4'b1000 || ack_o !== 4'b1000 || fifo_wr_data_o !== 10'h3A3) begin
                n_bad++; $display("FAIL drop_owner3_word%0d: got grant %b ack %b data %h want 1000/1000/3a3", w, grant_o, ack_o, fifo_wr_data_o);
            end
            tick();
        end
        #1;
        n_cmp++;
        if (grant_o !== 4'b0001 || fifo_wr_data_o !== 10'h0A0) begin
            n_bad++; $display("FAIL drop_then0: got grant %b data %h want 0001/0a0", grant_o, fifo_wr_data_o);
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        req_i = 4'b1111;
        #1;
        tick();
        repeat (5) tick();
        #1;
        n_cmp++;
        if (grant_o !== 4'b0010) begin
            n_bad++; $display("FAIL rmid_owner1: got %b want 0010", grant_o);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (grant_o !== 4'b0000 || fifo_wr_en_o !== 1'b0 || ack_o !== 4'b0000 || busy_o !== 1'b0) begin
            n_bad++; $display("FAIL rmid_async: got grant %b wr_en %b ack %b busy %b want 0000/0/0000/0", grant_o, fifo_wr_en_o, ack_o, busy_o);
        end
        tick();
        n_cmp++;
        if (grant_o !== 4'b0000 || fifo_wr_en_o !== 1'b0) begin
            n_bad++; $display("FAIL rmid_held: got grant %b wr_en %b want 0000/0", grant_o, fifo_wr_en_o);
        end
        rst_n = 1'b1;
        #1;
        tick();
        #1;
        n_cmp++;
        if (grant_o !== 4'b0001 || fifo_wr_data_o !== 10'h0A0) begin
            n_bad++; $display("FAIL rmid_regrant: got grant %b data %h want 0001/0a0", grant_o, fifo_wr_data_o);
        end
    endtask

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        rst_n       = 1'b0;
        req_i       = 4'b0000;
        fifo_full_i = 1'b0;
        data_i      = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        test_reset();
        test_single();
        test_all_req();
        test_full_stall();
        test_drop();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
